// File: rtl/frame_streamer_pkg.sv
// rtl/frame_streamer_pkg.sv - shared FSM state type, widths and class codes for frame_streamer
// Ports: none (package).
package frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_REPORT   = 3'd4
    } state_e;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;

    localparam logic [3:0] CLS_INVALID = 4'hF;
    localparam logic [3:0] CLS_TIMEOUT = 4'hE;

endpackage

// File: rtl/frame_streamer_if.sv
// rtl/frame_streamer_if.sv - host, network and result signals of frame_streamer
// Ports: none; signals grouped with modports slave (the streamer) and master (host/network side).
interface frame_streamer_if #(
    parameter int AW = 10
);
    // host side
    logic                                        wr_en;
    logic [AW-1:0]                               wr_addr;
    logic [frame_streamer_pkg::DATA_W-1:0]       wr_data;
    logic                                        start;
    logic                                        busy;
    // network side
    logic                                        load;
    logic                                        load_weight_done;
    logic                                        sof;
    logic                                        input_valid;
    logic [frame_streamer_pkg::DATA_W-1:0]       d_in;
    logic                                        output_valid;
    logic [frame_streamer_pkg::NUM_CLASSES-1:0]  d_out;
    // decoded result
    logic                                        class_valid;
    logic [3:0]                                  class_idx;
    logic                                        class_err;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, load_weight_done, output_valid, d_out,
        output busy, load, sof, input_valid, d_in, class_valid, class_idx, class_err
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, load_weight_done, output_valid, d_out,
        input  busy, load, sof, input_valid, d_in, class_valid, class_idx, class_err
    );

endinterface

// File: rtl/frame_streamer_onehot_decoder.sv
// rtl/frame_streamer_onehot_decoder.sv - combinational one-hot to class index decoder
// Ports: onehot_i (NUM_CLASSES) in; idx_o (4) bit position or CLS_INVALID; err_o (1) set unless exactly one bit.
module onehot_decoder
    import frame_streamer_pkg::*;
(
    input  logic [NUM_CLASSES-1:0] onehot_i,
    output logic [3:0]             idx_o,
    output logic                   err_o
);

    logic [3:0] ones;
    logic [3:0] pos;

    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (onehot_i[i]) begin
                ones = ones + 4'd1;
                pos  = 4'(i);
            end
        end
        if (ones == 4'd1) begin
            idx_o = pos;
            err_o = 1'b0;
        end else begin
            idx_o = CLS_INVALID;
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - buffers a host frame, streams it into a classifier network and decodes the result
// Ports: clk (1) in; rst (1) in, async active-low; bus (frame_streamer_if.slave) host writes/start/busy,
//        weight load handshake, pixel stream out, network result in, decoded class out.
// Option: FRAME_STREAMER_TIMEOUT_EN adds a WAIT_RES watchdog that reports CLS_TIMEOUT after TIMEOUT_CYCLES.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int FRAME_WORDS    = 1024,
    parameter int AW             = 10,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_streamer_if.slave        bus
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_LOAD_W   = ST_LOAD_W;
    localparam logic [2:0] S_STREAM   = ST_STREAM;
    localparam logic [2:0] S_WAIT_RES = ST_WAIT_RES;
    localparam logic [2:0] S_REPORT   = ST_REPORT;

    localparam logic [AW-1:0] LAST_WORD = AW'(FRAME_WORDS - 1);

    if ((1 << AW) < FRAME_WORDS) begin : g_bad_aw
        $error("frame_streamer: 2**AW must be >= FRAME_WORDS");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("frame_streamer: TIMEOUT_CYCLES must be >= 1");
    end

    logic [DATA_W-1:0] frame_mem [0:(1<<AW)-1];

    logic [2:0]        state_q, state_d;
    logic              weights_loaded_q;
    logic [AW-1:0]     rd_cnt_q;
    logic              issue_done_q;
    // read stage (memory output) and output stage (registered stream)
    logic              rd_vld_q, rd_sof_q, rd_last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              in_last_q;
    logic              input_valid_q, sof_q;
    logic [DATA_W-1:0] d_in_q;
    logic              busy_q, load_q;
    logic              class_valid_q, class_err_q;
    logic [3:0]        class_idx_q;

    logic              issuing;
    logic              timeout_hit;
    logic [3:0]        dec_idx;
    logic              dec_err;

    onehot_decoder u_dec (
        .onehot_i (bus.d_out),
        .idx_o    (dec_idx),
        .err_o    (dec_err)
    );

`ifdef FRAME_STREAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_q;

    assign timeout_hit = (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_WAIT_RES) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // One read is issued per STREAM cycle until the last word; the two
    // register stages mean the stream trails the issue by two cycles.
    assign issuing = (state_q == S_STREAM) && !issue_done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.start) state_d = weights_loaded_q ? S_STREAM : S_LOAD_W;
            S_LOAD_W:   if (bus.load_weight_done) state_d = S_STREAM;
            S_STREAM:   if (in_last_q) state_d = S_WAIT_RES;
            S_WAIT_RES: if (bus.output_valid || timeout_hit) state_d = S_REPORT;
            S_REPORT:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == S_IDLE)) begin
            frame_mem[bus.wr_addr] <= bus.wr_data;
        end
        rd_data_q <= frame_mem[rd_cnt_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            weights_loaded_q <= 1'b0;
            rd_cnt_q         <= '0;
            issue_done_q     <= 1'b0;
            rd_vld_q         <= 1'b0;
            rd_sof_q         <= 1'b0;
            rd_last_q        <= 1'b0;
            in_last_q        <= 1'b0;
            input_valid_q    <= 1'b0;
            sof_q            <= 1'b0;
            d_in_q           <= '0;
            busy_q           <= 1'b0;
            load_q           <= 1'b0;
            class_valid_q    <= 1'b0;
            class_idx_q      <= '0;
            class_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == S_LOAD_W) && bus.load_weight_done) begin
                weights_loaded_q <= 1'b1;
            end

            // counter holds at the last word instead of wrapping
            if (issuing) begin
                if (rd_cnt_q == LAST_WORD) begin
                    issue_done_q <= 1'b1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end
            end else if (state_q != S_STREAM) begin
                rd_cnt_q     <= '0;
                issue_done_q <= 1'b0;
            end

            rd_vld_q      <= issuing;
            rd_sof_q      <= issuing && (rd_cnt_q == '0);
            rd_last_q     <= issuing && (rd_cnt_q == LAST_WORD);
            input_valid_q <= rd_vld_q;
            sof_q         <= rd_sof_q;
            in_last_q     <= rd_last_q;
            d_in_q        <= rd_vld_q ? rd_data_q : '0;

            busy_q        <= (state_d != S_IDLE);
            load_q        <= (state_d == S_LOAD_W);
            class_valid_q <= (state_d == S_REPORT);

            if ((state_q == S_WAIT_RES) && bus.output_valid) begin
                class_idx_q <= dec_idx;
                class_err_q <= dec_err;
            end else if (state_d == S_REPORT) begin
                class_idx_q <= CLS_TIMEOUT;
                class_err_q <= 1'b1;
            end else begin
                class_idx_q <= '0;
                class_err_q <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.load        = load_q;
    assign bus.sof         = sof_q;
    assign bus.input_valid = input_valid_q;
    assign bus.d_in        = d_in_q;
    assign bus.class_valid = class_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.class_err   = class_err_q;

endmodule

// File: tb/tb_frame_streamer.sv
// tb/tb_frame_streamer.sv - self-checking bench for frame_streamer
module tb_frame_streamer;
    import frame_streamer_pkg::*;

    localparam int FW     = 1024;
    localparam int AW     = 10;
    localparam int TO     = 100;
    localparam int BUDGET = 4000;

    typedef struct {
        logic [9:0] d_out;
        logic [3:0] idx;
        logic       err;
        int         delay;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_streamer_if #(.AW(AW)) fs ();

    frame_streamer #(
        .FRAME_WORDS    (FW),
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fs)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [FW];
    bit          model_wl = 1'b0;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [9:0] v, output logic [3:0] idx, output logic err);
        if ($countones(v) == 1) begin
            idx = 4'($clog2(v));
            err = 1'b0;
        end else begin
            idx = 4'hF;
            err = 1'b1;
        end
    endfunction

    task automatic quiet_inputs();
        fs.wr_en            = 1'b0;
        fs.wr_addr          = '0;
        fs.wr_data          = '0;
        fs.start            = 1'b0;
        fs.load_weight_done = 1'b0;
        fs.output_valid     = 1'b0;
        fs.d_out            = '0;
    endtask

    task automatic noise();
        fs.wr_en        = 1'($urandom_range(0, 1));
        fs.wr_addr      = AW'($urandom);
        fs.wr_data      = $urandom;
        fs.start        = ($urandom_range(0, 7) == 0);
        fs.output_valid = 1'($urandom_range(0, 1));
        fs.d_out        = 10'($urandom);
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        fs.wr_en   = 1'b1;
        fs.wr_addr = AW'(a);
        fs.wr_data = d;
        model_mem[a] = d;
        @(negedge clk);
        fs.wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},        fs.busy, 0);
        check({tag, "_load"},        fs.load, 0);
        check({tag, "_sof"},         fs.sof, 0);
        check({tag, "_input_valid"}, fs.input_valid, 0);
        check({tag, "_d_in"},        fs.d_in, 0);
        check({tag, "_class_valid"}, fs.class_valid, 0);
        check({tag, "_class_idx"},   fs.class_idx, 0);
        check({tag, "_class_err"},   fs.class_err, 0);
    endtask

    // Starts a frame from IDLE and follows it until the first cycle after the
    // last streamed word (or until the mid-frame reset at word rst_at).
    task automatic run_frame(input string tag, input int poke_at, input int rst_at,
                             input bit wr_with_start, output logic [31:0] last_d);
        bit          exp_load, prev_v, aborted;
        int          cyc, nv, first, load_cnt, cv_cnt, gaps, sof_err, data_err;
        logic [31:0] d0;
        exp_load = !model_wl;
        aborted  = 1'b0;
        last_d   = '0;
        nv = 0; first = -1; load_cnt = 0; cv_cnt = 0; gaps = 0; sof_err = 0; data_err = 0;
        fs.start = 1'b1;
        if (wr_with_start) begin
            d0 = $urandom;
            fs.wr_en = 1'b1; fs.wr_addr = '0; fs.wr_data = d0;
            model_mem[0] = d0;
        end
        @(negedge clk);
        quiet_inputs();
        cyc    = 1;
        prev_v = 1'b0;
        while (cyc < BUDGET) begin
            if (fs.load) load_cnt++;
            if (fs.class_valid) cv_cnt++;
            if (fs.input_valid) begin
                if (nv == 0) first = cyc;
                else if (!prev_v) gaps++;
                if (nv < FW) begin
                    if (fs.sof !== (nv == 0)) sof_err++;
                    if (fs.d_in !== model_mem[nv]) data_err++;
                end
                last_d = fs.d_in;
                if (rst_at >= 0 && nv == rst_at) begin
                    rst = 1'b0;
                    quiet_inputs();
                    #1;
                    check_reset_outputs({tag, "_midreset"});
                    @(negedge clk);
                    rst      = 1'b1;
                    model_wl = 1'b0;
                    aborted  = 1'b1;
                    break;
                end
                nv++;
            end else if (fs.sof) begin
                sof_err++;
            end
            prev_v = fs.input_valid;
            if (nv >= FW && !fs.input_valid) break;
            noise();
            fs.load_weight_done = exp_load && (cyc == 20);
            if (poke_at >= 0 && fs.input_valid && nv == poke_at + 1) begin
                fs.wr_en   = 1'b1;
                fs.wr_addr = AW'(7);
                fs.wr_data = ~model_mem[7];
                fs.start   = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        quiet_inputs();
        if (!aborted) begin
            check({tag, "_load_cycles"},   load_cnt, exp_load ? 20 : 0);
            check({tag, "_first_valid"},   first, exp_load ? 23 : 3);
            check({tag, "_word_count"},    nv, FW);
            check({tag, "_gaps"},          gaps, 0);
            check({tag, "_sof_errors"},    sof_err, 0);
            check({tag, "_data_errors"},   data_err, 0);
            check({tag, "_early_class"},   cv_cnt, 0);
            check({tag, "_busy_wait_res"}, fs.busy, 1);
            model_wl = 1'b1;
        end
    endtask

    // Called on the first WAIT_RES cycle: idles, then delivers the network result.
    task automatic finish_result(input string tag, input vec_t v);
        int bad, bad2;
        bad = 0; bad2 = 0;
        repeat (v.delay) begin
            if (!fs.busy || fs.class_valid || fs.input_valid) bad++;
            fs.d_out = 10'($urandom);
            @(negedge clk);
        end
        check({tag, "_wait_res_hold"}, bad, 0);
        fs.output_valid = 1'b1;
        fs.d_out        = v.d_out;
        @(negedge clk);
        fs.output_valid = 1'b0;
        fs.d_out        = 10'($urandom);
        check({tag, "_class_valid"}, fs.class_valid, 1);
        check({tag, "_class_idx"},   fs.class_idx, v.idx);
        check({tag, "_class_err"},   fs.class_err, v.err);
        @(negedge clk);
        check({tag, "_class_valid_drop"}, fs.class_valid, 0);
        check({tag, "_busy_drop"},        fs.busy, 0);
        repeat (4) begin
            @(negedge clk);
            if (fs.busy || fs.input_valid || fs.class_valid) bad2++;
        end
        check({tag, "_idle_quiet"}, bad2, 0);
    endtask

    initial begin
        logic [31:0] last;
        logic [9:0]  d;
        int          n, bad;
        quiet_inputs();

        vecs[0] = '{10'b0000100000, 4'd5, 1'b0, 0};
        vecs[1] = '{10'b0000000000, 4'hF, 1'b1, 3};
        vecs[2] = '{10'b1000000001, 4'hF, 1'b1, 7};
        for (int i = 3; i < 7; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 10'(1 << $urandom_range(0, 9)) : 10'($urandom);
            vecs[i].d_out = d;
            ref_decode(d, vecs[i].idx, vecs[i].err);
            vecs[i].delay = $urandom_range(0, 50);
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int a = 0; a < FW; a++) host_write(a, 32'(a * 3));

        run_frame("f1", -1, -1, 1'b0, last);
        check("f1_last_word", last, 32'd3069);
        finish_result("f1", vecs[0]);

        run_frame("f2_poke", 100, -1, 1'b0, last);
        finish_result("f2", vecs[1]);

        run_frame("f3", -1, -1, 1'b1, last);
        finish_result("f3", vecs[2]);

        for (int k = 3; k < 6; k++) begin
            n = $urandom_range(1, 40);
            repeat (n) host_write($urandom_range(0, FW - 1), $urandom);
            run_frame($sformatf("rand%0d", k), $urandom_range(0, FW - 1), -1,
                      1'($urandom_range(0, 1)), last);
            finish_result($sformatf("rand%0d", k), vecs[k]);
        end

        run_frame("f_wd", -1, -1, 1'b0, last);
`ifdef FRAME_STREAMER_TIMEOUT_EN
        n = 0;
        while (!fs.class_valid && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles",    n, TO);
        check("timeout_class_idx", fs.class_idx, 4'hE);
        check("timeout_class_err", fs.class_err, 1);
        @(negedge clk);
        check("timeout_busy_drop", fs.busy, 0);
`else
        bad = 0;
        repeat (300) begin
            if (!fs.busy || fs.class_valid) bad++;
            @(negedge clk);
        end
        check("no_timeout_hold", bad, 0);
        vecs[6].delay = 0;
        finish_result("f_wd", vecs[6]);
`endif

        run_frame("f_rst", -1, 500, 1'b0, last);
        check("f_rst_last_word", last, model_mem[500]);

        run_frame("f_reload", -1, -1, 1'b0, last);
        finish_result("f_reload", vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 1024, meaning 32-bit words per input frame.
REQ-002 SHALL have parameter AW, default 10, meaning frame-buffer address width; the constraint is 2**AW >= FRAME_WORDS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2**20, meaning the result watchdog limit (see REQ-024).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  host write strobe into frame buffer.
REQ-007 wr_addr  in  AW  host write word address.
REQ-008 wr_data  in  32  host write word.
REQ-009 start  in  1  single-cycle request to classify the buffered frame.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 load  out  1  weight-load request to the network.
REQ-012 load_weight_done  in  1  weight-load complete from the network.
REQ-013 sof / input_valid / d_in  out  1/1/32  pixel stream into the network.
REQ-014 output_valid  in  1  network result strobe.
REQ-015 d_out  in  10  one-hot network result.
REQ-016 class_valid / class_idx / class_err  out  1/4/1  decoded result, valid for one cycle.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_W, STREAM, WAIT_RES and REPORT.
  - IDLE: start goes to LOAD_W if weights are not yet loaded, else to STREAM.
  - LOAD_W: load held high until load_weight_done is sampled high; then set the weights_loaded flag and go to STREAM.
  - STREAM: after the last word, go to WAIT_RES.
  - WAIT_RES: first output_valid high goes to REPORT.
  - REPORT: one cycle, then IDLE.
REQ-018 weights_loaded SHALL persist until reset, so load is issued only for the first frame after reset.
REQ-019 In STREAM, input_valid SHALL be high for exactly FRAME_WORDS consecutive cycles, carrying buffer words 0..FRAME_WORDS-1 in order.
  - sof is high only with word 0.
  - Outputs are registered; buffer read latency is 1 cycle and is hidden by prefetch.
  - The first input_valid occurs 2 cycles after entering STREAM.
REQ-020 Host writes SHALL be accepted only in IDLE; wr_en while busy is ignored and the buffer is unchanged.
REQ-021 start while busy SHALL be ignored (not queued); start and wr_en in the same IDLE cycle commit the write before streaming reads that address.
REQ-022 output_valid outside WAIT_RES SHALL be ignored.
REQ-023 Decode of d_out in REPORT:
  - Exactly one bit set: class_idx = that bit position (0..9), class_err = 0.
  - Zero or more than one bit set: class_idx = 4'hF, class_err = 1.
  - class_valid is high only in REPORT.
REQ-024 If TIMEOUT_CYCLES elapse in WAIT_RES without output_valid, the FSM SHALL go to REPORT with class_err = 1 and class_idx = 4'hE (only when FRAME_STREAMER_TIMEOUT_EN is defined).
REQ-025 The stream word counter SHALL be FRAME_WORDS-sized, with no wrap beyond FRAME_WORDS-1.

Reset
REQ-026 On rst low, asynchronously:
  - FSM goes to IDLE; counters and weights_loaded clear.
  - busy, load, sof, input_valid, class_valid and class_err = 0; d_in = 0; class_idx = 0.
REQ-027 Reset mid-STREAM SHALL drop input_valid immediately; the frame buffer contents are not required to be cleared.

Configuration
REQ-028 Macro FRAME_STREAMER_TIMEOUT_EN:
  - Defined: the WAIT_RES watchdog counter and REQ-024 behaviour are present.
  - Undefined: there is no counter, and WAIT_RES waits indefinitely for output_valid.

Structure
REQ-029 Shared package frame_streamer_pkg SHALL hold:
  - the FSM state enum;
  - NUM_CLASSES = 10;
  - DATA_W = 32;
  - class code constants CLS_INVALID = 4'hF and CLS_TIMEOUT = 4'hE.
REQ-030 The one-hot to index decode SHALL be a separate combinational sub-module onehot_decoder (10 in, 4-bit index + err out); the frame buffer is an inferred single-port-write, single-port-read array inside frame_streamer.

Verification
REQ-031 Write words 0..1023 with value addr*3, pulse start (first frame) → load high until load_weight_done is pulsed at cycle 20; then 1024 consecutive input_valid, sof only on d_in=0, last d_in=3069.
REQ-032 Second start after reset-free completion → load stays 0; STREAM begins directly and first input_valid occurs 3 cycles after start.
REQ-033 d_out=10'b0000100000 with output_valid in WAIT_RES → class_valid for 1 cycle, class_idx=5, class_err=0; then busy=0.
REQ-034 d_out=10'b0000000000 and 10'b1000000001 → class_idx=4'hF, class_err=1.
REQ-035 wr_en to addr 7 and a start pulse during STREAM → buffer word 7 unchanged on the next frame, no extra frame streamed; rst low at word 500 → input_valid=0 immediately, and the next start reissues load.
REQ-036 FRAME_STREAMER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, no output_valid → class_valid at cycle 100 of WAIT_RES with class_idx=4'hE, class_err=1; with the macro undefined, busy stays 1.
